// File: rtl/ceespu_dmem_pkg.sv
// Shared types and constants for the ceespu data-memory responder.
package ceespu_dmem_pkg;

    localparam int unsigned REGION_BIT   = 15;
    localparam logic [15:0] RAM_BASE     = 16'h0000;
    localparam logic [15:0] PERIPH_BASE  = RAM_BASE | 16'(1 << REGION_BIT);
    localparam int unsigned DEF_TIMEOUT  = 255;
    localparam logic [31:0] DEF_ERR_DATA = 32'hDEADBEEF;
    localparam int unsigned TMO_W        = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } dmem_state_e;

    typedef enum logic {
        RGN_RAM,
        RGN_PERIPH
    } region_e;

    // Region is decided by the top address bit alone; no wrap from 0xFFFF into RAM.
    function automatic region_e region_of(input logic [15:0] addr);
        return ((addr & PERIPH_BASE) != RAM_BASE) ? RGN_PERIPH : RGN_RAM;
    endfunction

endpackage

// File: rtl/ceespu_dmem_bram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
module ceespu_dmem_bram #(
    parameter int unsigned WORDS = 8192,
    parameter int unsigned AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [WORDS];

    // Writes commit per lane; the read register only updates on reads so stores leave it intact.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            if (we == 4'b0000) begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/ceespu_dmem_responder.sv
// CPU data-memory responder: local byte-lane BRAM below 0x8000, req/ack peripheral bridge above.
module ceespu_dmem_responder
    import ceespu_dmem_pkg::*;
#(
    parameter int unsigned RAM_WORDS = 8192,
    parameter int unsigned TIMEOUT   = DEF_TIMEOUT,
    parameter logic [31:0] ERR_DATA  = DEF_ERR_DATA
) (
    input  logic        I_clk,
    input  logic        I_rst_n,
    input  logic [15:0] I_memAddress,
    input  logic        I_memE,
    input  logic [3:0]  I_memWe,
    input  logic [31:0] I_wData,
    output logic [31:0] O_rData,
    output logic        O_busy,
    output logic        O_bus_req,
    output logic [15:0] O_bus_addr,
    output logic [31:0] O_bus_wdata,
    output logic [3:0]  O_bus_we,
    input  logic        I_bus_ack,
    input  logic [31:0] I_bus_rdata,
    output logic        O_bus_err
);

    localparam int unsigned RAM_AW = $clog2(RAM_WORDS);

    dmem_state_e      state;
    logic [TMO_W-1:0] tmo_cnt;
    logic [31:0]      bus_cap;
    logic [31:0]      periph_data;
    logic [31:0]      ram_rdata;
    region_e          rd_sel;
    logic             is_periph;
    logic             start;
    logic             ram_en;

    assign is_periph = (region_of(I_memAddress) == RGN_PERIPH);
    assign start     = (state == ST_IDLE) && I_memE && is_periph;
    assign ram_en    = (state == ST_IDLE) && I_memE && !is_periph;

    // Stall must rise in the request cycle itself, so it is decoded rather than registered.
    assign O_busy  = I_rst_n && (start || (state == ST_WAIT));
    assign O_rData = (rd_sel == RGN_PERIPH) ? periph_data : ram_rdata;

    ceespu_dmem_bram #(
        .WORDS (RAM_WORDS),
        .AW    (RAM_AW)
    ) u_bram (
        .clk   (I_clk),
        .en    (ram_en),
        .we    (I_memWe),
        .addr  (I_memAddress[RAM_AW+1:2]),
        .wdata (I_wData),
        .rdata (ram_rdata)
    );

    // Peripheral bridge FSM; captured data is published to O_rData only on leaving DONE.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state       <= ST_IDLE;
            tmo_cnt     <= '0;
            O_bus_req   <= 1'b0;
            O_bus_addr  <= '0;
            O_bus_wdata <= '0;
            O_bus_we    <= '0;
            O_bus_err   <= 1'b0;
            bus_cap     <= '0;
            periph_data <= '0;
            rd_sel      <= RGN_PERIPH;
        end else begin
            if (ram_en && (I_memWe == 4'b0000)) begin
                rd_sel <= RGN_RAM;
            end
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        O_bus_addr  <= I_memAddress;
                        O_bus_wdata <= I_wData;
                        O_bus_we    <= I_memWe;
                        O_bus_req   <= 1'b1;
                        tmo_cnt     <= '0;
                        state       <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (I_bus_ack) begin
                        if (O_bus_we == 4'b0000) begin
                            bus_cap <= I_bus_rdata;
                        end
                        O_bus_req <= 1'b0;
                        state     <= ST_DONE;
                    end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                        if (O_bus_we == 4'b0000) begin
                            bus_cap <= ERR_DATA;
                        end
                        O_bus_err <= 1'b1;
                        O_bus_req <= 1'b0;
                        state     <= ST_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                ST_DONE: begin
                    if (O_bus_we == 4'b0000) begin
                        periph_data <= bus_cap;
                        rd_sel      <= RGN_PERIPH;
                    end
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ceespu_dmem_responder.sv
// Randomized scoreboard bench for ceespu_dmem_responder against a transaction-level model.
module tb_ceespu_dmem_responder;

    localparam int          TMO = 255;
    localparam logic [31:0] ERR = 32'hDEADBEEF;

    logic        I_clk = 1'b0;
    logic        I_rst_n;
    logic [15:0] I_memAddress;
    logic        I_memE;
    logic [3:0]  I_memWe;
    logic [31:0] I_wData;
    logic [31:0] O_rData;
    logic        O_busy;
    logic        O_bus_req;
    logic [15:0] O_bus_addr;
    logic [31:0] O_bus_wdata;
    logic [3:0]  O_bus_we;
    logic        I_bus_ack;
    logic [31:0] I_bus_rdata;
    logic        O_bus_err;

    ceespu_dmem_responder dut (
        .I_clk        (I_clk),
        .I_rst_n      (I_rst_n),
        .I_memAddress (I_memAddress),
        .I_memE       (I_memE),
        .I_memWe      (I_memWe),
        .I_wData      (I_wData),
        .O_rData      (O_rData),
        .O_busy       (O_busy),
        .O_bus_req    (O_bus_req),
        .O_bus_addr   (O_bus_addr),
        .O_bus_wdata  (O_bus_wdata),
        .O_bus_we     (O_bus_we),
        .I_bus_ack    (I_bus_ack),
        .I_bus_rdata  (I_bus_rdata),
        .O_bus_err    (O_bus_err)
    );

    always #5 I_clk = ~I_clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          busy;
        int          rises;
        int          hi;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        cur;
    int          n_checks = 0;
    int          n_pass   = 0;

    logic [31:0] mem_m [int];
    logic [31:0] last_rd;
    logic        err_m;
    logic [12:0] pool [16];

    int          tx_k;
    logic [31:0] tx_rdata;
    logic [15:0] tx_addr;
    logic [3:0]  tx_we;
    logic [31:0] tx_wdata;

    int          mon_busy, mon_rises, mon_hi, per_w;
    logic        mon_prev_req, mon_pend;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    // Issue one CPU request; expectation is derived from the memory map rules, not DUT state.
    task automatic do_tx(input logic [15:0] a, input logic [3:0] we, input logic [31:0] wd,
                         input int k, input logic [31:0] rd);
        exp_t        e;
        int          n;
        bit          acked;
        bit          done;
        int          idx;
        logic [31:0] w;
        idx = int'(a[14:2]);
        if (!a[15]) begin
            if (we == 4'b0000) begin
                last_rd = mem_m[idx];
            end else begin
                w = mem_m.exists(idx) ? mem_m[idx] : 32'h0;
                for (int i = 0; i < 4; i++) if (we[i]) w[8*i +: 8] = wd[8*i +: 8];
                mem_m[idx] = w;
            end
            e = '{rdata: last_rd, err: err_m, busy: 0, rises: 0, hi: 0};
        end else begin
            acked = (k >= 1) && (k <= TMO);
            n = acked ? k : TMO;
            if (!acked) err_m = 1'b1;
            if (we == 4'b0000) last_rd = acked ? rd : ERR;
            e = '{rdata: last_rd, err: err_m, busy: 1 + n, rises: 1, hi: n};
        end
        sb_q.push_back(e);
        tx_k = k; tx_rdata = rd; tx_addr = a; tx_we = we; tx_wdata = wd;
        @(posedge I_clk); #1;
        I_memE = 1'b1; I_memAddress = a; I_memWe = we; I_wData = wd;
        done = 1'b0;
        for (int c = 0; c < TMO + 8 && !done; c++) begin
            @(negedge I_clk);
            if (!O_busy) done = 1'b1;
        end
        if (!done) check("accept_timeout", 32'(done), 32'h1);
    endtask

    task automatic go_idle();
        @(posedge I_clk); #1;
        I_memE = 1'b0;
    endtask

    // Peripheral model: acks in the tx_k-th request cycle, sprays stray acks when idle.
    initial begin
        I_bus_ack = 1'b0; I_bus_rdata = '0; per_w = 0;
        forever begin
            @(posedge I_clk); #1;
            I_bus_rdata = $urandom;
            if (O_bus_req) begin
                per_w++;
                I_bus_ack = (per_w == tx_k);
                if (I_bus_ack) begin
                    I_bus_rdata = tx_rdata;
                    check("bus_addr", 32'(O_bus_addr), 32'(tx_addr));
                    check("bus_we", 32'(O_bus_we), 32'(tx_we));
                    check("bus_wdata", O_bus_wdata, tx_wdata);
                end
            end else begin
                per_w = 0;
                I_bus_ack = ($urandom_range(0, 7) == 0);
            end
        end
    end

    // Monitor: a request completes when held with busy low; its results appear one cycle later.
    initial begin
        mon_busy = 0; mon_rises = 0; mon_hi = 0; mon_prev_req = 1'b0; mon_pend = 1'b0;
        forever begin
            @(negedge I_clk);
            if (!I_rst_n) begin
                mon_busy = 0; mon_rises = 0; mon_hi = 0; mon_prev_req = 1'b0; mon_pend = 1'b0;
            end else begin
                if (mon_pend) begin
                    check("rdata", O_rData, cur.rdata);
                    check("bus_err", 32'(O_bus_err), 32'(cur.err));
                    mon_pend = 1'b0;
                end
                if (O_bus_req) begin
                    mon_hi++;
                    if (!mon_prev_req) mon_rises++;
                end
                mon_prev_req = O_bus_req;
                if (I_memE) begin
                    if (O_busy) begin
                        mon_busy++;
                    end else if (sb_q.size() == 0) begin
                        check("sb_underflow", 32'(sb_q.size()), 32'h1);
                    end else begin
                        cur = sb_q.pop_front();
                        check("busy_cycles", 32'(mon_busy), 32'(cur.busy));
                        check("req_pulses", 32'(mon_rises), 32'(cur.rises));
                        check("req_cycles", 32'(mon_hi), 32'(cur.hi));
                        mon_busy = 0; mon_rises = 0; mon_hi = 0;
                        mon_pend = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        I_rst_n = 1'b0; I_memE = 1'b0; I_memAddress = '0; I_memWe = '0; I_wData = '0;
        tx_k = 0; tx_rdata = '0; tx_addr = '0; tx_we = '0; tx_wdata = '0;
        err_m = 1'b0; last_rd = '0;
        repeat (3) @(posedge I_clk);
        #1;
        check("rst_busy", 32'(O_busy), 32'h0);
        check("rst_req", 32'(O_bus_req), 32'h0);
        check("rst_rdata", O_rData, 32'h0);
        check("rst_err", 32'(O_bus_err), 32'h0);
        check("rst_bus_addr", 32'(O_bus_addr), 32'h0);
        check("rst_bus_wdata", O_bus_wdata, 32'h0);
        check("rst_bus_we", 32'(O_bus_we), 32'h0);
        #1 I_rst_n = 1'b1;

        // Directed scenarios from the memory-map rules.
        do_tx(16'h0010, 4'b1111, 32'h12345678, 0, 0);
        do_tx(16'h0010, 4'b0000, 32'h0, 0, 0);
        do_tx(16'h0010, 4'b0101, 32'hAABBCCDD, 0, 0);
        do_tx(16'h0012, 4'b0000, 32'h0, 0, 0);
        do_tx(16'h8004, 4'b0000, 32'h0, 3, 32'hCAFEF00D);
        do_tx(16'h8008, 4'b0000, 32'h0, 1, 32'h0BADF00D);
        do_tx(16'hFFFF, 4'b1010, 32'h55667788, 2, 32'h0);
        do_tx(16'h8010, 4'b0000, 32'h0, TMO, 32'h600DDA7A);
        do_tx(16'h8020, 4'b0000, 32'h0, 0, 32'h0);
        do_tx(16'h8024, 4'b0000, 32'h0, 2, 32'h13579BDF);
        do_tx(16'h0010, 4'b0000, 32'h0, 0, 0);

        // Reset while the bridge is waiting for an ack that never comes.
        tx_k = 0;
        @(posedge I_clk); #1;
        I_memE = 1'b1; I_memAddress = 16'h8100; I_memWe = 4'b0000;
        repeat (3) @(posedge I_clk);
        #3 I_rst_n = 1'b0;
        #1;
        check("rstw_busy", 32'(O_busy), 32'h0);
        check("rstw_req", 32'(O_bus_req), 32'h0);
        check("rstw_err", 32'(O_bus_err), 32'h0);
        I_memE = 1'b0;
        repeat (2) @(posedge I_clk);
        #2 I_rst_n = 1'b1;
        err_m = 1'b0; last_rd = '0;
        do_tx(16'h0010, 4'b0000, 32'h0, 0, 0);

        // Randomized traffic over a small pool of RAM words plus the peripheral window.
        foreach (pool[i]) begin
            pool[i] = 13'($urandom);
            do_tx({1'b0, pool[i], 2'b00}, 4'b1111, $urandom, 0, 0);
        end
        for (int t = 0; t < 300; t++) begin
            logic [15:0] a;
            logic [3:0]  we;
            int          k, r;
            if ($urandom_range(0, 1) == 0) a = {1'b0, pool[$urandom_range(0, 15)], 2'($urandom)};
            else if ($urandom_range(0, 19) == 0) a = 16'hFFFF;
            else a = {1'b1, 15'($urandom)};
            we = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
            r = $urandom_range(0, 99);
            if (r < 2) k = 0;
            else if (r < 4) k = TMO;
            else k = $urandom_range(1, 6);
            do_tx(a, we, $urandom, k, $urandom);
        end
        go_idle();
        repeat (3) @(negedge I_clk);
        check("sb_drained", 32'(sb_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
